// File: rtl/car_lane_engine.sv
// Four car lanes: per-frame position update with wrap across a virtual track,
// plus registered per-pixel hit flags for the colour stage.
module car_lane_engine #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned CAR_W    = 64,
    parameter int unsigned CAR_H    = 32,
    parameter int unsigned LANE1_Y  = 96,
    parameter int unsigned LANE2_Y  = 160,
    parameter int unsigned LANE3_Y  = 224,
    parameter int unsigned LANE4_Y  = 288,
    parameter int unsigned SPEED1   = 1,
    parameter int unsigned SPEED2   = 2,
    parameter int unsigned SPEED3   = 3,
    parameter int unsigned SPEED4   = 4,
    parameter int unsigned DIR1     = 1,
    parameter int unsigned DIR2     = 0,
    parameter int unsigned DIR3     = 1,
    parameter int unsigned DIR4     = 0,
    parameter int unsigned INIT1    = 0,
    parameter int unsigned INIT2    = 200,
    parameter int unsigned INIT3    = 400,
    parameter int unsigned INIT4    = 600
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       enable,
    input  logic       frame_tick,
    input  logic [1:0] level,
    input  logic       video_on,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic       boxC1,
    output logic       boxC2,
    output logic       boxC3,
    output logic       boxC4,
    output logic [9:0] car1_x,
    output logic [9:0] car2_x,
    output logic [9:0] car3_x,
    output logic [9:0] car4_x
);
    localparam int unsigned W = H_ACTIVE + CAR_W;

    localparam int unsigned LANE_Y [4] = '{LANE1_Y, LANE2_Y, LANE3_Y, LANE4_Y};
    localparam int unsigned SPEED  [4] = '{SPEED1, SPEED2, SPEED3, SPEED4};
    localparam int unsigned DIR    [4] = '{DIR1, DIR2, DIR3, DIR4};
    localparam int unsigned INIT   [4] = '{INIT1, INIT2, INIT3, INIT4};

    logic [10:0] w_px;
    logic [10:0] w_py;

    assign w_px = {1'b0, pix_x};
    assign w_py = {1'b0, pix_y};

    for (genvar g = 0; g < 4; g++) begin : g_car
        if (SPEED[g] + 3 >= W) begin : g_bad_speed
            $error("car_lane_engine: SPEED + max level must be below track width");
        end
        if (INIT[g] >= W) begin : g_bad_init
            $error("car_lane_engine: INIT must be below track width");
        end

        logic [9:0]  r_x;
        logic        r_box;
        logic [10:0] w_step;
        logic [10:0] w_x;
        logic [10:0] w_sum;
        logic [9:0]  w_next;
        logic        w_hit;

        assign w_step = 11'(SPEED[g]) + {9'b0, level};
        assign w_x    = {1'b0, r_x};

        // Wrap keeps the track a closed ring of W positions in both directions.
        always_comb begin
            w_sum = w_x + w_step;
            if (DIR[g] != 0) begin
                w_next = (w_sum >= 11'(W)) ? 10'(w_sum - 11'(W)) : 10'(w_sum);
            end else begin
                w_next = (w_x >= w_step) ? 10'(w_x - w_step) : 10'(w_x + 11'(W) - w_step);
            end
        end

        // Car occupies columns x-CAR_W .. x-1; pre-update position is used.
        assign w_hit = video_on
                     & (w_py >= 11'(LANE_Y[g]))
                     & (w_py <  11'(LANE_Y[g] + CAR_H))
                     & (w_px + 11'(CAR_W) >= w_x)
                     & (w_px < w_x);

        always_ff @(posedge clk_in) begin
            if (reset) begin
                r_x   <= 10'(INIT[g]);
                r_box <= 1'b0;
            end else begin
                r_box <= w_hit;
                if (frame_tick && enable) begin
                    r_x <= w_next;
                end
            end
        end
    end

    assign car1_x = g_car[0].r_x;
    assign car2_x = g_car[1].r_x;
    assign car3_x = g_car[2].r_x;
    assign car4_x = g_car[3].r_x;
    assign boxC1  = g_car[0].r_box;
    assign boxC2  = g_car[1].r_box;
    assign boxC3  = g_car[2].r_box;
    assign boxC4  = g_car[3].r_box;
endmodule

// File: tb/tb_car_lane_engine.sv
// Randomized and directed checks of car_lane_engine against a ring-track model;
// a second instance with INIT3=702/INIT4=2 exercises the wrap paths.
module tb_car_lane_engine;
    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       frame_tick;
    logic [1:0] level;
    logic       video_on;
    logic [9:0] pix_x;
    logic [9:0] pix_y;

    logic [9:0] a_x [4];
    logic [9:0] b_x [4];
    logic [3:0] a_box;
    logic [3:0] b_box;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int TRACK = 704;
    localparam int LANES [4] = '{96, 160, 224, 288};
    localparam int SPDS  [4] = '{1, 2, 3, 4};
    localparam int DIRS  [4] = '{1, 0, 1, 0};
    localparam int INITS [2][4] = '{'{0, 200, 400, 600}, '{0, 200, 702, 2}};

    int m_x   [2][4];
    bit m_box [2][4];

    always #5 clk = ~clk;

    car_lane_engine u_dut_a (
        .clk_in(clk), .reset(reset), .enable(enable), .frame_tick(frame_tick),
        .level(level), .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y),
        .boxC1(a_box[0]), .boxC2(a_box[1]), .boxC3(a_box[2]), .boxC4(a_box[3]),
        .car1_x(a_x[0]), .car2_x(a_x[1]), .car3_x(a_x[2]), .car4_x(a_x[3])
    );

    car_lane_engine #(.INIT3(702), .INIT4(2)) u_dut_b (
        .clk_in(clk), .reset(reset), .enable(enable), .frame_tick(frame_tick),
        .level(level), .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y),
        .boxC1(b_box[0]), .boxC2(b_box[1]), .boxC3(b_box[2]), .boxC4(b_box[3]),
        .car1_x(b_x[0]), .car2_x(b_x[1]), .car3_x(b_x[2]), .car4_x(b_x[3])
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_hit(int x, int lane);
        int px = int'(pix_x);
        int py = int'(pix_y);
        return video_on && (py >= lane) && (py < lane + 32) && (px >= x - 64) && (px < x);
    endfunction

    // Model of one clock edge, using the inputs currently driven.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 4; c++) begin
                if (reset) begin
                    m_x[i][c]   = INITS[i][c];
                    m_box[i][c] = 1'b0;
                end else begin
                    m_box[i][c] = model_hit(m_x[i][c], LANES[c]);
                    if (frame_tick && enable) begin
                        if (DIRS[c] == 1) m_x[i][c] = (m_x[i][c] + SPDS[c] + int'(level)) % TRACK;
                        else              m_x[i][c] = (m_x[i][c] - SPDS[c] - int'(level) + TRACK) % TRACK;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < 4; c++) begin
            check_eq($sformatf("a_car%0d_x", c + 1), int'(a_x[c]), m_x[0][c]);
            check_eq($sformatf("b_car%0d_x", c + 1), int'(b_x[c]), m_x[1][c]);
            check_eq($sformatf("a_boxC%0d", c + 1), int'(a_box[c]), int'(m_box[0][c]));
            check_eq($sformatf("b_boxC%0d", c + 1), int'(b_box[c]), int'(m_box[1][c]));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic tick_frame();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        int k;
        int inst;
        int px;
        reset = 1'b1; enable = 1'b1; frame_tick = 1'b1; level = 2'd0;
        video_on = 1'b0; pix_x = '0; pix_y = '0;
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 4; c++) begin
                m_x[i][c] = 0;
                m_box[i][c] = 1'b0;
            end

        // Reset wins over frame_tick/enable
        repeat (3) cyc();
        check_eq("rst_car1", int'(a_x[0]), 0);
        check_eq("rst_car2", int'(a_x[1]), 200);
        check_eq("rst_car3", int'(a_x[2]), 400);
        check_eq("rst_car4", int'(a_x[3]), 600);
        check_eq("rst_boxes", int'(a_box), 0);

        reset = 1'b0;
        cyc();
        frame_tick = 1'b0;
        cyc();
        check_eq("t1_car1", int'(a_x[0]), 1);
        check_eq("t1_car2", int'(a_x[1]), 198);
        check_eq("t1_car3", int'(a_x[2]), 403);
        check_eq("t1_car4", int'(a_x[3]), 596);
        check_eq("wrap1_car3", int'(b_x[2]), 1);
        check_eq("wrap1_car4", int'(b_x[3]), 702);
        repeat (10) cyc();
        check_eq("idle_car2", int'(a_x[1]), 198);
        check_eq("idle_car4", int'(a_x[3]), 596);
        tick_frame();
        check_eq("wrap2_car3", int'(b_x[2]), 4);
        check_eq("wrap2_car4", int'(b_x[3]), 698);

        // Hit compare around car1_x = 100
        do_reset();
        level = 2'd3;
        repeat (25) tick_frame();
        check_eq("hit_setup_car1", int'(a_x[0]), 100);
        level = 2'd0;
        video_on = 1'b1; pix_y = 10'd100;
        pix_x = 10'd36;  cyc(); check_eq("hit_px36", int'(a_box[0]), 1);
        pix_x = 10'd99;  cyc(); check_eq("hit_px99", int'(a_box[0]), 1);
        pix_x = 10'd100; cyc(); check_eq("hit_px100", int'(a_box[0]), 0);
        pix_x = 10'd35;  cyc(); check_eq("hit_px35", int'(a_box[0]), 0);
        pix_x = 10'd50; pix_y = 10'd128; cyc(); check_eq("hit_py128", int'(a_box[0]), 0);
        pix_y = 10'd127; cyc(); check_eq("hit_py127", int'(a_box[0]), 1);
        video_on = 1'b0; cyc(); check_eq("hit_vid_off", int'(a_box[0]), 0);

        // Left screen edge, car1_x = 10
        do_reset();
        repeat (10) tick_frame();
        check_eq("edge_setup_car1", int'(a_x[0]), 10);
        video_on = 1'b1; pix_x = 10'd0; pix_y = 10'd100;
        cyc(); check_eq("edge_px0", int'(a_box[0]), 1);

        // enable=0 freezes positions
        do_reset();
        enable = 1'b0;
        repeat (5) tick_frame();
        check_eq("frz_car1", int'(a_x[0]), 0);
        check_eq("frz_car2", int'(a_x[1]), 200);
        level = 2'd3; enable = 1'b1;
        tick_frame();
        check_eq("lvl3_car1", int'(a_x[0]), 4);
        check_eq("lvl3_car2", int'(a_x[1]), 195);

        // Reset mid-line while boxC2 is set
        do_reset();
        level = 2'd0;
        video_on = 1'b1; pix_x = 10'd150; pix_y = 10'd170;
        cyc(); check_eq("ml_box2_pre", int'(a_box[1]), 1);
        reset = 1'b1;
        cyc(); check_eq("ml_box2_rst", int'(a_box[1]), 0);
        check_eq("ml_car2_rst", int'(a_x[1]), 200);
        reset = 1'b0;
        cyc(); check_eq("ml_box2_resume", int'(a_box[1]), 1);

        // Randomized traffic with pixels aimed near the cars
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom % 200) == 0;
            enable     = ($urandom % 8) != 0;
            frame_tick = ($urandom % 6) == 0;
            level      = 2'($urandom);
            video_on   = ($urandom % 5) != 0;
            k    = int'($urandom_range(0, 3));
            inst = int'($urandom_range(0, 1));
            pix_y = 10'(LANES[k] - 4 + int'($urandom_range(0, 40)));
            px = m_x[inst][k] - int'($urandom_range(0, 70));
            if (px < 0) px = 0;
            if (px > 639) px = 639;
            pix_x = 10'(px);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
